// File: rtl/sram_like_arb.sv
// Shares one sram-like master port between inst and data requesters; an owner FIFO routes in-order responses back.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration, otherwise data has fixed priority over inst.
module sram_like_arb #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_cache,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_cache,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_cache,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {FREE, LOCK} state_t;

  state_t           state, state_nxt;
  logic             lock_owner, lock_owner_nxt;
  logic [DEPTH-1:0] owner_q;
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             pick, sel, sel_req, not_full, accept, pop, head;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  // With both pending, grant whoever did not win last; a lone requester always wins.
  always_comb begin
    pick = data_req;
    if (inst_req && data_req) pick = ~last_grant;
  end

  always_ff @(posedge clock) begin
    if (reset) last_grant <= 1'b1;
    else if (accept && inst_req && data_req) last_grant <= ~last_grant;
  end
`else
  assign pick = data_req;
`endif

  assign sel      = (state == LOCK) ? lock_owner : pick;
  assign sel_req  = sel ? data_req : inst_req;
  // Full check uses registered count, so a same-cycle pop never frees a slot early.
  assign not_full = (count != (AW+1)'(DEPTH));
  assign m_req    = sel_req & not_full;
  assign m_wr     = sel ? data_wr    : inst_wr;
  assign m_size   = sel ? data_size  : inst_size;
  assign m_addr   = sel ? data_addr  : inst_addr;
  assign m_wdata  = sel ? data_wdata : inst_wdata;
  assign m_cache  = sel ? data_cache : inst_cache;

  assign accept       = m_req & m_addr_ok;
  assign inst_addr_ok = accept & ~sel;
  assign data_addr_ok = accept & sel;

  assign head         = owner_q[rptr];
  assign pop          = m_data_ok & (count != '0);
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  always_comb begin
    state_nxt      = state;
    lock_owner_nxt = lock_owner;
    case (state)
      FREE: if (m_req && !m_addr_ok) begin
        state_nxt      = LOCK;
        lock_owner_nxt = sel;
      end
      LOCK: if (m_addr_ok) state_nxt = FREE;
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FREE;
      lock_owner <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      lock_owner <= lock_owner_nxt;
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept) owner_q[wptr] <= sel;
  end
endmodule

// File: tb/tb_sram_like_arb.sv
// Directed bench for sram_like_arb: the bench plays both requesters and the bridge; a monitor checks ok pulses against queues.
module tb_sram_like_arb;
  logic        clock = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_cache, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_cache, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        m_req, m_wr, m_cache, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  typedef struct packed {
    logic        owner;
    logic [31:0] val;
  } exp_t;

  exp_t acc_q[$];
  exp_t rsp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;

  sram_like_arb #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_cache(inst_cache), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_cache(data_cache), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_cache(m_cache), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ok pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (inst_addr_ok || data_addr_ok) begin
      if (acc_q.size() == 0) begin
        check("spurious_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      end else begin
        e = acc_q.pop_front();
        check("acc_owner", 32'({inst_addr_ok, data_addr_ok}), e.owner ? 32'd1 : 32'd2);
        check("acc_addr", m_addr, e.val);
      end
    end
    if (inst_data_ok || data_data_ok) begin
      if (rsp_q.size() == 0) begin
        check("spurious_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_owner", 32'({inst_data_ok, data_data_ok}), e.owner ? 32'd1 : 32'd2);
        check("rsp_rdata", e.owner ? data_rdata : inst_rdata, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic who, input logic on, input logic [31:0] addr);
    if (who == DATA) begin
      data_req = on; data_addr = addr;
    end else begin
      inst_req = on; inst_addr = addr;
    end
  endtask

  task automatic issue(input logic who, input logic [31:0] addr);
    set_req(who, 1'b1, addr);
    m_addr_ok = 1'b1;
    acc_q.push_back('{who, addr});
    step();
    set_req(who, 1'b0, addr);
    m_addr_ok = 1'b0;
  endtask

  task automatic respond(input logic who, input logic [31:0] rdata);
    m_data_ok = 1'b1;
    m_rdata   = rdata;
    rsp_q.push_back('{who, rdata});
    step();
    m_data_ok = 1'b0;
  endtask

  // First requester stalls 3 cycles; the other arrives mid-stall and must wait.
  task automatic lock_test(input logic first, input logic [31:0] a, input logic [31:0] b);
    set_req(first, 1'b1, a);
    m_addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) set_req(~first, 1'b1, b);
      if (k == 3) begin
        m_addr_ok = 1'b1;
        acc_q.push_back('{first, a});
      end
      @(negedge clock);
      check("lock_addr", m_addr, a);
      check("lock_mreq", 32'(m_req), 32'd1);
      step();
    end
    set_req(first, 1'b0, a);
    acc_q.push_back('{~first, b});
    step();
    set_req(~first, 1'b0, b);
    m_addr_ok = 1'b0;
    respond(first, a ^ 32'hFFFF_0000);
    respond(~first, b ^ 32'hFFFF_0000);
  endtask

  initial begin
    logic first;
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0; inst_cache = 1;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0; data_cache = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    step(); step();
    reset = 1'b0;
    // Reset state: no request; a stray data_ok with nothing outstanding is ignored.
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
    @(negedge clock);
    check("rst_mreq", 32'(m_req), 32'd0);
    check("rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    step();
    m_addr_ok = 1'b0; m_data_ok = 1'b0;

    // Single inst read, response three cycles after accept.
    issue(INST, 32'hBFC0_0000);
    step(); step();
    respond(INST, 32'h3C1D_0001);
    m_data_ok = 1'b1;
    step();
    m_data_ok = 1'b0;

    // Both requesters at once with addr_ok held high.
`ifdef SRAM_ARB_RR_EN
    first = INST;
`else
    first = DATA;
`endif
    set_req(INST, 1'b1, 32'h0000_1000);
    set_req(DATA, 1'b1, 32'h0000_2000);
    m_addr_ok = 1'b1;
    acc_q.push_back('{first, first ? 32'h0000_2000 : 32'h0000_1000});
    acc_q.push_back('{~first, first ? 32'h0000_1000 : 32'h0000_2000});
    step();
    set_req(first, 1'b0, first ? 32'h0000_2000 : 32'h0000_1000);
    step();
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
    respond(first, 32'hAAAA_0001);
    respond(~first, 32'hAAAA_0002);

    lock_test(DATA, 32'h0000_8000, 32'h0000_9000);
    lock_test(INST, 32'h0000_A000, 32'h0000_B000);

    // Fill the owner FIFO, then check the full stall including a same-cycle pop.
    for (int i = 0; i < 4; i++) begin
      set_req(DATA, 1'b1, 32'h0000_3000 + 32'(4 * i));
      m_addr_ok = 1'b1;
      acc_q.push_back('{DATA, 32'h0000_3000 + 32'(4 * i)});
      step();
    end
    set_req(DATA, 1'b1, 32'h0000_3010);
    m_data_ok = 1'b1; m_rdata = 32'hC000_0000;
    rsp_q.push_back('{DATA, 32'hC000_0000});
    @(negedge clock);
    check("full_mreq", 32'(m_req), 32'd0);
    step();
    m_data_ok = 1'b0;
    acc_q.push_back('{DATA, 32'h0000_3010});
    @(negedge clock);
    check("refill_mreq", 32'(m_req), 32'd1);
    step();
    data_req = 1'b0; m_addr_ok = 1'b0;
    for (int i = 1; i < 5; i++) respond(DATA, 32'hC000_0000 + 32'(i));

    // Interleaved inst/data/inst with a push and pop in the same cycle.
    set_req(INST, 1'b1, 32'h0000_4000);
    m_addr_ok = 1'b1;
    acc_q.push_back('{INST, 32'h0000_4000});
    step();
    inst_req = 1'b0;
    set_req(DATA, 1'b1, 32'h0000_5000);
    data_wr = 1'b1; data_size = 2'd1; data_wdata = 32'hDEAD_BEEF;
    acc_q.push_back('{DATA, 32'h0000_5000});
    @(negedge clock);
    check("wr_mwr", 32'(m_wr), 32'd1);
    check("wr_msize", 32'(m_size), 32'd1);
    check("wr_mwdata", m_wdata, 32'hDEAD_BEEF);
    step();
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;
    set_req(INST, 1'b1, 32'h0000_4004);
    acc_q.push_back('{INST, 32'h0000_4004});
    m_data_ok = 1'b1; m_rdata = 32'h0000_00A1;
    rsp_q.push_back('{INST, 32'h0000_00A1});
    step();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    m_rdata = 32'h0000_00A2;
    rsp_q.push_back('{DATA, 32'h0000_00A2});
    step();
    m_rdata = 32'h0000_00A3;
    rsp_q.push_back('{INST, 32'h0000_00A3});
    step();
    step();
    m_data_ok = 1'b0;

    // Reset with two outstanding and the grant locked on data.
    issue(INST, 32'h0000_6000);
    issue(DATA, 32'h0000_6004);
    set_req(DATA, 1'b1, 32'h0000_6008);
    step();
    reset = 1'b1;
    data_req = 1'b0;
    step();
    reset = 1'b0;
    set_req(INST, 1'b1, 32'h0000_7000);
    @(negedge clock);
    check("postrst_mreq", 32'(m_req), 32'd1);
    check("postrst_maddr", m_addr, 32'h0000_7000);
    check("postrst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    step();
    m_addr_ok = 1'b1;
    acc_q.push_back('{INST, 32'h0000_7000});
    step();
    inst_req = 1'b0; m_addr_ok = 1'b0;
    respond(INST, 32'h0000_7777);
    m_data_ok = 1'b1;
    step();
    m_data_ok = 1'b0;
    step();

    check("acc_q_left", 32'(acc_q.size()), 32'd0);
    check("rsp_q_left", 32'(rsp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
